// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a word-wide req/ack refill bus.
// Hits are resolved at acceptance so o_rvalid follows one cycle later; misses stall on o_ready.
module dcache_dm_wb #(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned ADDR_LENGTH = 32,
  parameter int unsigned NUM_LINES   = 64,
  parameter int unsigned LINE_WORDS  = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_valid,
  input  logic                   i_rw,
  input  logic [ADDR_LENGTH-1:0] i_addr,
  input  logic [DATA_LENGTH-1:0] i_wdata,
  input  logic [DATA_LENGTH-1:0] i_wmask,
  output logic                   o_ready,
  output logic [DATA_LENGTH-1:0] o_rdata,
  output logic                   o_rvalid,
  output logic                   o_mem_req,
  output logic                   o_mem_we,
  output logic [ADDR_LENGTH-1:0] o_mem_addr,
  output logic [DATA_LENGTH-1:0] o_mem_wdata,
  input  logic                   i_mem_ack,
  input  logic [DATA_LENGTH-1:0] i_mem_rdata
);

  localparam int unsigned WordBits = $clog2(LINE_WORDS);
  localparam int unsigned IdxBits  = $clog2(NUM_LINES);
  localparam int unsigned TagBits  = ADDR_LENGTH - 2 - WordBits - IdxBits;
  localparam logic [WordBits-1:0] LastWord = WordBits'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StWriteback,
    StRefill,
    StRespond
  } state_e;

  // Storage
  logic [DATA_LENGTH-1:0] data_q [NUM_LINES*LINE_WORDS];
  logic [TagBits-1:0]     tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0]   valid_q;
  logic [NUM_LINES-1:0]   dirty_q;

  // Control and latched request
  state_e                 state_q;
  logic                   rw_q;
  logic                   hit_q;
  logic [TagBits-1:0]     req_tag_q;
  logic [IdxBits-1:0]     req_idx_q;
  logic [WordBits-1:0]    req_word_q;
  logic [DATA_LENGTH-1:0] wdata_q;
  logic [DATA_LENGTH-1:0] wmask_q;
  logic [WordBits-1:0]    cnt_q;

  // Registered outputs
  logic                   ready_q;
  logic                   rvalid_q;
  logic [DATA_LENGTH-1:0] rdata_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [ADDR_LENGTH-1:0] mem_addr_q;
  logic [DATA_LENGTH-1:0] mem_wdata_q;

  // Incoming-request decode, used to resolve hits in the acceptance cycle
  logic [WordBits-1:0]    in_word;
  logic [IdxBits-1:0]     in_idx;
  logic [TagBits-1:0]     in_tag;
  logic                   in_hit;
  logic [DATA_LENGTH-1:0] in_old;
  logic [DATA_LENGTH-1:0] in_merged;

  // Latched-request view, used by RESPOND and the line transfer phases
  logic [DATA_LENGTH-1:0] req_old;
  logic [DATA_LENGTH-1:0] req_merged;
  logic [TagBits-1:0]     victim_tag;
  logic                   last_word;
  logic                   unused_addr;

  assign in_word   = i_addr[2 +: WordBits];
  assign in_idx    = i_addr[2 + WordBits +: IdxBits];
  assign in_tag    = i_addr[ADDR_LENGTH-1 -: TagBits];
  assign in_hit    = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign in_old    = data_q[{in_idx, in_word}];
  assign in_merged = (in_old & ~i_wmask) | (i_wdata & i_wmask);

  assign req_old    = data_q[{req_idx_q, req_word_q}];
  assign req_merged = (req_old & ~wmask_q) | (wdata_q & wmask_q);
  assign victim_tag = tag_q[req_idx_q];
  assign last_word  = (cnt_q == LastWord);

  assign unused_addr = ^i_addr[1:0];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      hit_q       <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // ready_q low in IDLE means a completion pulse is ending or reset just released
          if (!ready_q) begin
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
          end else if (i_valid) begin
            ready_q    <= 1'b0;
            rw_q       <= i_rw;
            req_tag_q  <= in_tag;
            req_idx_q  <= in_idx;
            req_word_q <= in_word;
            wdata_q    <= i_wdata;
            wmask_q    <= i_wmask;
            hit_q      <= in_hit;
            state_q    <= StLookup;
            if (in_hit) begin
              rvalid_q <= 1'b1;
              if (i_rw) begin
                data_q[{in_idx, in_word}] <= in_merged;
                dirty_q[in_idx]           <= 1'b1;
                rdata_q                   <= in_merged;
              end else begin
                rdata_q <= in_old;
              end
            end
          end
        end

        StLookup: begin
          cnt_q <= '0;
          if (hit_q) begin
            state_q  <= StIdle;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
          end else if (valid_q[req_idx_q] && dirty_q[req_idx_q]) begin
            state_q <= StWriteback;
          end else begin
            state_q <= StRefill;
          end
        end

        StWriteback: begin
          if (mem_req_q) begin
            if (i_mem_ack) begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              if (last_word) begin
                cnt_q              <= '0;
                dirty_q[req_idx_q] <= 1'b0;
                state_q            <= StRefill;
              end else begin
                cnt_q <= cnt_q + WordBits'(1);
              end
            end
          end else begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {victim_tag, req_idx_q, cnt_q, 2'b00};
            mem_wdata_q <= data_q[{req_idx_q, cnt_q}];
          end
        end

        StRefill: begin
          if (mem_req_q) begin
            if (i_mem_ack) begin
              mem_req_q                   <= 1'b0;
              data_q[{req_idx_q, cnt_q}] <= i_mem_rdata;
              if (last_word) begin
                cnt_q              <= '0;
                tag_q[req_idx_q]   <= req_tag_q;
                valid_q[req_idx_q] <= 1'b1;
                dirty_q[req_idx_q] <= 1'b0;
                state_q            <= StRespond;
              end else begin
                cnt_q <= cnt_q + WordBits'(1);
              end
            end
          end else begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {req_tag_q, req_idx_q, cnt_q, 2'b00};
            mem_wdata_q <= '0;
          end
        end

        StRespond: begin
          // Write mask applies only here; the refill already replaced the whole line
          rvalid_q <= 1'b1;
          state_q  <= StIdle;
          if (rw_q) begin
            data_q[{req_idx_q, req_word_q}] <= req_merged;
            dirty_q[req_idx_q]              <= 1'b1;
            rdata_q                         <= req_merged;
          end else begin
            rdata_q <= req_old;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = rdata_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_dm_wb.sv
// Directed bench for dcache_dm_wb: cold miss, hits, masked write, dirty eviction,
// reset during refill and back-to-back hits, against a 2-cycle-ack memory model.
module tb_dcache_dm_wb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] wmask = '0;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int req_cycles = 0;

  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] log_addr [$];
  logic        log_we [$];
  logic [31:0] log_data [$];

  dcache_dm_wb dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_valid     (valid),
    .i_rw        (rw),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_wmask     (wmask),
    .o_ready     (ready),
    .o_rdata     (rdata),
    .o_rvalid    (rvalid),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (mem_req) req_cycles++;
  end

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: ack is raised after the request has been seen for two cycles
  int mcnt = 0;
  always @(posedge clk) begin
    #1;
    if (mem_ack) begin
      mem_ack = 1'b0;
      mcnt    = 0;
    end else if (mem_req) begin
      mcnt++;
      if (mcnt == 2) begin
        mem_ack = 1'b1;
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        if (mem_we) begin
          mem_store[mem_addr] = mem_wdata;
          log_data.push_back(mem_wdata);
        end else begin
          mem_rdata = mem_read(mem_addr);
          log_data.push_back(mem_rdata);
        end
      end
    end else begin
      mcnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check_eq("ready_timeout", 32'(ready), 32'd1);
  endtask

  task automatic do_req(input logic r_w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] wm, output logic [31:0] rd, output int lat);
    wait_ready();
    valid = 1'b1;
    rw    = r_w;
    addr  = a;
    wdata = wd;
    wmask = wm;
    @(posedge clk);
    #1;
    valid = 1'b0;
    lat   = 1;
    while (!rvalid && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rvalid) check_eq("rvalid_timeout", 32'(rvalid), 32'd1);
    check_eq("ready_low_with_rvalid", 32'(ready), 32'd0);
    rd = rdata;
  endtask

  task automatic check_line(input string tag, input int base, input logic we,
                            input logic [31:0] a0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), log_addr[base+i], a0 + 32'(4*i));
      check_eq($sformatf("%s_we%0d", tag, i), 32'(log_we[base+i]), 32'(we));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int lat;
    int rq0;
    int guard;
    int last_cyc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we), 32'd0);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("ready_after_release", 32'(ready), 32'd1);

    // Cold read miss
    clear_log();
    do_req(1'b0, 32'h100, '0, '0, rd, lat);
    check_eq("cold_rdata", rd, 32'hA5A5_0100);
    check_eq("cold_nxfer", 32'(log_addr.size()), 32'd4);
    check_line("cold_rd", 0, 1'b0, 32'h100);

    // Hit on another word of the resident line
    rq0 = req_cycles;
    do_req(1'b0, 32'h108, '0, '0, rd, lat);
    check_eq("hit_rdata", rd, 32'hA5A5_0108);
    check_eq("hit_latency", 32'(lat), 32'd1);
    check_eq("hit_no_mem", 32'(req_cycles - rq0), 32'd0);

    // Masked write hit then read back
    rq0 = req_cycles;
    do_req(1'b1, 32'h104, 32'h0000_AB00, 32'h0000_FF00, rd, lat);
    check_eq("wr_latency", 32'(lat), 32'd1);
    do_req(1'b0, 32'h104, '0, '0, rd, lat);
    check_eq("wr_readback", rd, 32'hA5A5_AB04);
    check_eq("wr_no_mem", 32'(req_cycles - rq0), 32'd0);

    // Conflict miss evicts the dirty line first
    clear_log();
    do_req(1'b0, 32'h500, '0, '0, rd, lat);
    check_eq("evict_rdata", rd, 32'hA5A5_0500);
    check_eq("evict_nxfer", 32'(log_addr.size()), 32'd8);
    check_line("evict_wb", 0, 1'b1, 32'h100);
    check_line("evict_rf", 4, 1'b0, 32'h500);
    check_eq("evict_wb_w0", log_data[0], 32'hA5A5_0100);
    check_eq("evict_wb_w1", log_data[1], 32'hA5A5_AB04);
    check_eq("evict_wb_w3", log_data[3], 32'hA5A5_010C);

    // Reset while waiting for the second refill ack of a clean miss
    clear_log();
    wait_ready();
    valid = 1'b1;
    rw    = 1'b0;
    addr  = 32'h900;
    @(posedge clk);
    #1;
    valid = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!(log_addr.size() == 1 && mem_req && !mem_ack) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check_eq("rstmid_reached", 32'(guard < 200), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstmid_mem_req", 32'(mem_req), 32'd0);
    check_eq("rstmid_rvalid", 32'(rvalid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    clear_log();
    do_req(1'b0, 32'h500, '0, '0, rd, lat);
    check_eq("rstmid_rdata", rd, 32'hA5A5_0500);
    check_eq("rstmid_nxfer", 32'(log_addr.size()), 32'd4);
    check_line("rstmid_rf", 0, 1'b0, 32'h500);

    // Back-to-back hits with i_valid held high
    wait_ready();
    valid    = 1'b1;
    rw       = 1'b0;
    last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      addr = (k % 2 == 0) ? 32'h500 : 32'h504;
      @(posedge clk);
      #1;
      check_eq($sformatf("b2b_rvalid%0d", k), 32'(rvalid), 32'd1);
      check_eq($sformatf("b2b_rdata%0d", k), rdata,
               (k % 2 == 0) ? 32'hA5A5_0500 : 32'hA5A5_0504);
      if (k > 0) check_eq($sformatf("b2b_period%0d", k), 32'(cyc - last_cyc), 32'd2);
      last_cyc = cyc;
      @(negedge clk);
      check_eq($sformatf("b2b_ready%0d", k), 32'(ready), 32'd0);
      @(negedge clk);
      check_eq($sformatf("b2b_ready_again%0d", k), 32'(ready), 32'd1);
    end
    valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
